// File: rtl/ctr_decoder.sv
// Receiver for the 4-bit control-code stream: shadows the encoder state and recovers ctrl bits in order.
// Optional macro CTR_DEC_STATS_EN adds a ones_cnt statistics counter with a stats_clr input.
module ctr_decoder #(
   parameter int ERR_CNT_W    = 8,
   parameter bit START_LOCKED = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           code,
   input  logic                 code_vld,
`ifdef CTR_DEC_STATS_EN
   input  logic                 stats_clr,
   output logic [15:0]          ones_cnt,
`endif
   output logic                 bit_vld,
   output logic                 bit_num,
   output logic [1:0]           bits,
   output logic                 locked,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [1:0]           shadow_state
);

   typedef enum logic [2:0] {
      ST_S0   = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_HUNT = 3'd4
   } state_e;

   localparam state_e RST_STATE = START_LOCKED ? ST_S0 : ST_HUNT;

   state_e                 state_q, state_d;
   logic                   pend_q, pend_d;
   logic                   bit_vld_q, bit_num_q, err_q;
   logic [1:0]             bits_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;

   logic                   emit_vld, emit_two, illegal;
   logic [1:0]             emit_bits;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      emit_vld  = 1'b0;
      emit_two  = 1'b0;
      emit_bits = 2'b00;
      illegal   = 1'b0;
      if (code_vld) begin
         unique case (state_q)
            ST_S0: begin
               if (code == 4'd6) begin
                  emit_vld = 1'b1; emit_bits = 2'b01; state_d = ST_S1;
               end else if (code == 4'd3) begin
                  emit_vld = 1'b1; state_d = ST_S2;
               end else if (code != 4'd0) begin
                  illegal = 1'b1;
               end
            end
            ST_S1: begin
               if (code == 4'd1) begin
                  emit_vld = 1'b1; emit_bits = 2'b01; state_d = ST_S2;
               end else if (code == 4'd2) begin
                  emit_vld = 1'b1;
               end else begin
                  illegal = 1'b1;
               end
            end
            ST_S2: begin
               if (code == 4'd1) begin
                  emit_vld = 1'b1; emit_bits = 2'b01; state_d = ST_S3;
               end else if (code == 4'd4) begin
                  emit_vld = 1'b1;
               end else begin
                  illegal = 1'b1;
               end
            end
            ST_S3: begin
               // A 0 code in S3 hides the ctrl bit; the following code decides it.
               if (!pend_q) begin
                  if (code == 4'd0) pend_d = 1'b1;
                  else              illegal = 1'b1;
               end else if (code == 4'd0) begin
                  emit_vld = 1'b1; emit_bits = 2'b01;
               end else if (code == 4'd6) begin
                  emit_vld = 1'b1; emit_two = 1'b1; emit_bits = 2'b10;
                  state_d = ST_S1; pend_d = 1'b0;
               end else if (code == 4'd3) begin
                  emit_vld = 1'b1; emit_two = 1'b1;
                  state_d = ST_S2; pend_d = 1'b0;
               end else begin
                  illegal = 1'b1;
               end
            end
            default: begin
               if (code == 4'd6) begin
                  emit_vld = 1'b1; emit_bits = 2'b01; state_d = ST_S1;
               end else if (code == 4'd3) begin
                  emit_vld = 1'b1; state_d = ST_S2;
               end
            end
         endcase
         if (illegal) begin
            state_d = ST_HUNT;
            pend_d  = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RST_STATE;
         pend_q    <= 1'b0;
         bit_vld_q <= 1'b0;
         bit_num_q <= 1'b0;
         bits_q    <= 2'b00;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         bit_vld_q <= emit_vld;
         bit_num_q <= emit_two;
         bits_q    <= emit_bits;
         err_q     <= illegal;
         if (illegal && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

`ifdef CTR_DEC_STATS_EN
   logic [15:0] ones_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || stats_clr) ones_cnt_q <= '0;
      else if (emit_vld)    ones_cnt_q <= ones_cnt_q + 16'(emit_bits[0]) + 16'(emit_bits[1]);
   end

   assign ones_cnt = ones_cnt_q;
`endif

   assign bit_vld      = bit_vld_q;
   assign bit_num      = bit_num_q;
   assign bits         = bits_q;
   assign err          = err_q;
   assign err_cnt      = err_cnt_q;
   assign locked       = (state_q != ST_HUNT);
   assign shadow_state = (state_q == ST_HUNT) ? 2'd0 : state_q[1:0];

endmodule

// File: tb/tb_ctr_decoder.sv
// Self-checking bench for ctr_decoder: directed scenarios plus randomized codes against a reference model.
// Two instances: ERR_CNT_W=8/START_LOCKED=1 and ERR_CNT_W=2/START_LOCKED=0.
module tb_ctr_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] code = 4'd0;
   logic       code_vld = 1'b0;
   logic       stats_clr = 1'b0;

   logic       a_vld, a_num, a_lock, a_err;
   logic [1:0] a_bits, a_sh;
   logic [7:0] a_cnt;
   logic       b_vld, b_num, b_lock, b_err;
   logic [1:0] b_bits, b_sh, b_cnt;
`ifdef CTR_DEC_STATS_EN
   logic [15:0] a_ones, b_ones;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ctr_decoder #(.ERR_CNT_W(8), .START_LOCKED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .code(code), .code_vld(code_vld),
`ifdef CTR_DEC_STATS_EN
      .stats_clr(stats_clr), .ones_cnt(a_ones),
`endif
      .bit_vld(a_vld), .bit_num(a_num), .bits(a_bits), .locked(a_lock),
      .err(a_err), .err_cnt(a_cnt), .shadow_state(a_sh)
   );

   ctr_decoder #(.ERR_CNT_W(2), .START_LOCKED(1'b0)) u_dut_w2 (
      .clk(clk), .rst(rst), .code(code), .code_vld(code_vld),
`ifdef CTR_DEC_STATS_EN
      .stats_clr(stats_clr), .ones_cnt(b_ones),
`endif
      .bit_vld(b_vld), .bit_num(b_num), .bits(b_bits), .locked(b_lock),
      .err(b_err), .err_cnt(b_cnt), .shadow_state(b_sh)
   );

   // Reference model: encoder-state tracking expressed as plain decode rules.
   typedef struct {
      bit       locked;
      int       s;
      bit       pend;
      int       cnt;
      int       cnt_max;
      int       ones;
      bit       vld;
      bit       num;
      bit [1:0] bits;
      bit       err;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset(bit start_locked, int cnt_max);
      mdl_t m;
      m = '{default: 0};
      m.locked  = start_locked;
      m.cnt_max = cnt_max;
      return m;
   endfunction

   function automatic mdl_t mdl_next(mdl_t m, int c, bit v, bit clr);
      mdl_t     r;
      bit       ok;
      int       n;
      bit [1:0] b;
      r = m; r.vld = 0; r.num = 0; r.bits = 0; r.err = 0;
      ok = 1; n = 0; b = 0;
      if (v) begin
         if (!m.locked) begin
            if (c == 6)      begin r.locked = 1; r.s = 1; n = 1; b = 2'b01; end
            else if (c == 3) begin r.locked = 1; r.s = 2; n = 1; end
         end else begin
            case (m.s)
               0: if (c == 6) begin r.s = 1; n = 1; b = 2'b01; end
                  else if (c == 3) begin r.s = 2; n = 1; end
                  else if (c != 0) ok = 0;
               1: if (c == 1) begin r.s = 2; n = 1; b = 2'b01; end
                  else if (c == 2) n = 1;
                  else ok = 0;
               2: if (c == 1) begin r.s = 3; n = 1; b = 2'b01; end
                  else if (c == 4) n = 1;
                  else ok = 0;
               default:
                  if (!m.pend) begin
                     if (c == 0) r.pend = 1; else ok = 0;
                  end else if (c == 0) begin n = 1; b = 2'b01; end
                  else if (c == 6) begin n = 2; b = 2'b10; r.s = 1; r.pend = 0; end
                  else if (c == 3) begin n = 2; b = 2'b00; r.s = 2; r.pend = 0; end
                  else ok = 0;
            endcase
         end
         if (!ok) begin
            r.err = 1; r.locked = 0; r.s = 0; r.pend = 0;
            r.cnt = (m.cnt < m.cnt_max) ? m.cnt + 1 : m.cnt_max;
         end else if (n > 0) begin
            r.vld = 1; r.num = (n == 2); r.bits = b;
            r.ones = (m.ones + int'(b[0]) + int'(b[1])) % 65536;
         end
      end
      if (clr) r.ones = 0;
      return r;
   endfunction

   // Drive one cycle at negedge, update the models at the edge, leave time at posedge+1.
   task automatic drive(input int c, input bit v, input bit r = 1'b0);
      @(negedge clk);
      code = 4'(c); code_vld = v; rst = r;
      @(posedge clk);
      if (r) begin
         ma = mdl_reset(1'b1, 255);
         mb = mdl_reset(1'b0, 3);
      end else begin
         ma = mdl_next(ma, c, v, stats_clr);
         mb = mdl_next(mb, c, v, stats_clr);
      end
      #1;
   endtask

   task automatic test_reset();
      drive(0, 1'b1, 1'b1);
      n_tests++;
      if (a_vld !== 1'b0 || a_err !== 1'b0 || a_cnt !== 8'd0 || a_lock !== 1'b1 || a_sh !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_a: vld=%b err=%b cnt=%0d lock=%b sh=%0d, expected 0 0 0 1 0",
                  a_vld, a_err, a_cnt, a_lock, a_sh);
      end
      n_tests++;
      if (b_vld !== 1'b0 || b_cnt !== 2'd0 || b_lock !== 1'b0 || b_sh !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_b: vld=%b cnt=%0d lock=%b sh=%0d, expected 0 0 0 0",
                  b_vld, b_cnt, b_lock, b_sh);
      end
   endtask

   task automatic test_decode();
      int codes[6]   = '{6, 1, 1, 0, 0, 3};
      bit ev[6]      = '{1, 1, 1, 0, 1, 1};
      bit en[6]      = '{0, 0, 0, 0, 0, 1};
      bit [1:0] eb[6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
      int codes2[4]  = '{6, 2, 2, 1};
      bit [1:0] eb2[4] = '{2'b01, 2'b00, 2'b00, 2'b01};
      drive(0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(codes[i], 1'b1);
         n_tests++;
         if (a_vld !== ev[i] || (ev[i] && (a_num !== en[i] || a_bits !== eb[i])) || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL decode[%0d]: vld=%b num=%b bits=%b err=%b, expected %b %b %b 0",
                     i, a_vld, a_num, a_bits, a_err, ev[i], en[i], eb[i]);
         end
      end
      n_tests++;
      if (a_sh !== 2'd2) begin
         n_fail++;
         $display("FAIL decode_shadow: got %0d expected 2", a_sh);
      end
      drive(0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(codes2[i], 1'b1);
         n_tests++;
         if (a_vld !== 1'b1 || a_num !== 1'b0 || a_bits !== eb2[i]) begin
            n_fail++;
            $display("FAIL decode2[%0d]: vld=%b num=%b bits=%b, expected 1 0 %b",
                     i, a_vld, a_num, a_bits, eb2[i]);
         end
      end
      n_tests++;
      if (a_sh !== 2'd2) begin
         n_fail++;
         $display("FAIL decode2_shadow: got %0d expected 2", a_sh);
      end
   endtask

   task automatic test_illegal_hunt();
      int ign[3] = '{4, 1, 0};
      drive(0, 1'b1, 1'b1);
      drive(5, 1'b1);
      n_tests++;
      if (a_err !== 1'b1 || a_cnt !== 8'd1 || a_lock !== 1'b0 || a_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal: err=%b cnt=%0d lock=%b vld=%b, expected 1 1 0 0", a_err, a_cnt, a_lock, a_vld);
      end
      for (int i = 0; i < 3; i++) begin
         drive(ign[i], 1'b1);
         n_tests++;
         if (a_err !== 1'b0 || a_cnt !== 8'd1 || a_lock !== 1'b0 || a_vld !== 1'b0 || a_sh !== 2'd0) begin
            n_fail++;
            $display("FAIL hunt_ignore[%0d]: err=%b cnt=%0d lock=%b vld=%b sh=%0d, expected 0 1 0 0 0",
                     i, a_err, a_cnt, a_lock, a_vld, a_sh);
         end
      end
      drive(3, 1'b1);
      n_tests++;
      if (a_lock !== 1'b1 || a_vld !== 1'b1 || a_bits !== 2'b00 || a_sh !== 2'd2) begin
         n_fail++;
         $display("FAIL relock: lock=%b vld=%b bits=%b sh=%0d, expected 1 1 00 2", a_lock, a_vld, a_bits, a_sh);
      end
   endtask

   task automatic test_gap();
      drive(0, 1'b1, 1'b1);
      drive(6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(int'($urandom_range(0, 15)), 1'b0);
         n_tests++;
         if (a_vld !== 1'b0 || a_err !== 1'b0 || a_sh !== 2'd1) begin
            n_fail++;
            $display("FAIL gap[%0d]: vld=%b err=%b sh=%0d, expected 0 0 1", i, a_vld, a_err, a_sh);
         end
      end
      drive(1, 1'b1);
      n_tests++;
      if (a_vld !== 1'b1 || a_bits !== 2'b01 || a_sh !== 2'd2) begin
         n_fail++;
         $display("FAIL after_gap: vld=%b bits=%b sh=%0d, expected 1 01 2", a_vld, a_bits, a_sh);
      end
   endtask

   task automatic test_reset_pending();
      int codes[4] = '{6, 1, 1, 0};
      drive(0, 1'b1, 1'b1);
      foreach (codes[i]) drive(codes[i], 1'b1);
      drive(0, 1'b1, 1'b1);
      n_tests++;
      if (a_vld !== 1'b0 || a_sh !== 2'd0 || a_lock !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pend: vld=%b sh=%0d lock=%b, expected 0 0 1", a_vld, a_sh, a_lock);
      end
      drive(3, 1'b1);
      n_tests++;
      if (a_vld !== 1'b1 || a_num !== 1'b0 || a_bits !== 2'b00 || a_sh !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_pend_next: vld=%b num=%b bits=%b sh=%0d, expected 1 0 00 2",
                  a_vld, a_num, a_bits, a_sh);
      end
   endtask

   task automatic test_saturate();
      bit [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      drive(0, 1'b1, 1'b1);
      drive(3, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(7, 1'b1);
         n_tests++;
         if (b_err !== 1'b1 || b_cnt !== exp_cnt[i] || b_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_err[%0d]: err=%b cnt=%0d lock=%b, expected 1 %0d 0", i, b_err, b_cnt, b_lock, exp_cnt[i]);
         end
         drive(3, 1'b1);
         n_tests++;
         if (b_lock !== 1'b1 || b_vld !== 1'b1 || b_bits !== 2'b00 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_relock[%0d]: lock=%b vld=%b bits=%b err=%b, expected 1 1 00 0",
                     i, b_lock, b_vld, b_bits, b_err);
         end
      end
   endtask

`ifdef CTR_DEC_STATS_EN
   task automatic test_stats();
      drive(0, 1'b1, 1'b1);
      drive(6, 1'b1);
      drive(1, 1'b1);
      n_tests++;
      if (a_ones !== 16'd2) begin
         n_fail++;
         $display("FAIL ones_cnt: got %0d expected 2", a_ones);
      end
      stats_clr = 1'b1;
      drive(1, 1'b1);
      stats_clr = 1'b0;
      n_tests++;
      if (a_ones !== 16'd0) begin
         n_fail++;
         $display("FAIL ones_clr: got %0d expected 0", a_ones);
      end
   endtask
`endif

   task automatic test_random();
      int c;
      bit v, r;
      drive(0, 1'b1, 1'b1);
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 99) < 85) begin
            case ($urandom_range(0, 5))
               0: c = 0; 1: c = 1; 2: c = 2; 3: c = 3; 4: c = 4; default: c = 6;
            endcase
         end else begin
            c = int'($urandom_range(0, 15));
         end
         stats_clr = ($urandom_range(0, 63) == 0);
         drive(c, v, r);
         n_tests++;
         if (a_vld !== ma.vld || (ma.vld && (a_num !== ma.num || a_bits !== ma.bits)) ||
             a_err !== ma.err || a_cnt !== 8'(ma.cnt) || a_lock !== ma.locked ||
             a_sh !== 2'(ma.locked ? ma.s : 0)) begin
            n_fail++;
            $display("FAIL rand_a[%0d]: vld=%b num=%b bits=%b err=%b cnt=%0d lock=%b sh=%0d, expected %b %b %b %b %0d %b %0d",
                     i, a_vld, a_num, a_bits, a_err, a_cnt, a_lock, a_sh,
                     ma.vld, ma.num, ma.bits, ma.err, ma.cnt, ma.locked, ma.locked ? ma.s : 0);
         end
         n_tests++;
         if (b_vld !== mb.vld || (mb.vld && (b_num !== mb.num || b_bits !== mb.bits)) ||
             b_err !== mb.err || b_cnt !== 2'(mb.cnt) || b_lock !== mb.locked ||
             b_sh !== 2'(mb.locked ? mb.s : 0)) begin
            n_fail++;
            $display("FAIL rand_b[%0d]: vld=%b num=%b bits=%b err=%b cnt=%0d lock=%b sh=%0d, expected %b %b %b %b %0d %b %0d",
                     i, b_vld, b_num, b_bits, b_err, b_cnt, b_lock, b_sh,
                     mb.vld, mb.num, mb.bits, mb.err, mb.cnt, mb.locked, mb.locked ? mb.s : 0);
         end
`ifdef CTR_DEC_STATS_EN
         n_tests++;
         if (a_ones !== 16'(ma.ones) || b_ones !== 16'(mb.ones)) begin
            n_fail++;
            $display("FAIL rand_ones[%0d]: got %0d/%0d expected %0d/%0d", i, a_ones, b_ones, ma.ones, mb.ones);
         end
`endif
      end
      stats_clr = 1'b0;
   endtask

   initial begin
      ma = mdl_reset(1'b1, 255);
      mb = mdl_reset(1'b0, 3);
      test_reset();
      test_decode();
      test_illegal_hunt();
      test_gap();
      test_reset_pending();
      test_saturate();
`ifdef CTR_DEC_STATS_EN
      test_stats();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
